// File: rtl/noise_injector.sv
// Channel-noise summing stage: buffers sporadic generator noise in a small FIFO and
// adds one noise sample to each channel sample with saturation, valid/ready output.
module noise_injector #(
    parameter int SIG_W      = 8,
    parameter int NOISE_W    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              en,
    input  logic                              bypass,
    input  logic                              clr_stats,
    input  logic signed [NOISE_W-1:0]         noise_in,
    input  logic                              noise_valid,
    input  logic signed [SIG_W-1:0]           sig_in,
    input  logic                              sig_valid,
    output logic                              sig_ready,
    output logic signed [SIG_W-1:0]           out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [CNT_W-1:0]                  noise_drop_cnt,
    output logic [CNT_W-1:0]                  sat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SIG_W-1:0] SIG_MAX  = {1'b0, {(SIG_W-1){1'b1}}};
    localparam logic [SIG_W-1:0] SIG_MIN  = {1'b1, {(SIG_W-1){1'b0}}};

    logic [NOISE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LW-1:0]      level;

    logic               fifo_full;
    logic               fifo_empty;
    logic               out_free;
    logic               accept;
    logic               push;
    logic               pop;
    logic               drop;
    logic               sat_event;
    logic [NOISE_W-1:0] noise_head;
    logic [SIG_W:0]     sig_ext;
    logic [SIG_W:0]     noise_ext;
    logic [SIG_W:0]     sum;
    logic [SIG_W-1:0]   sum_sat;

    assign fifo_full  = (level == FULL_LVL);
    assign fifo_empty = (level == '0);
    assign out_free   = !out_valid || out_ready;
    assign sig_ready  = en && out_free && (bypass || !fifo_empty);
    assign accept     = sig_valid && sig_ready;
    assign pop        = accept && !bypass;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push       = en && noise_valid && (!fifo_full || pop);
    assign drop       = en && noise_valid && fifo_full && !pop;

    assign noise_head = mem[rd_ptr];
    assign sig_ext    = {sig_in[SIG_W-1], sig_in};
    assign noise_ext  = {{(SIG_W+1-NOISE_W){noise_head[NOISE_W-1]}}, noise_head};
    assign sum        = sig_ext + noise_ext;

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sum_sat   = sum[SIG_W-1:0];
        sat_event = 1'b0;
        if (sum[SIG_W] != sum[SIG_W-1]) begin
            sat_event = pop;
            sum_sat   = sum[SIG_W] ? SIG_MIN : SIG_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= noise_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= bypass ? sig_in : sum_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            noise_drop_cnt <= '0;
            sat_cnt        <= '0;
        end else if (clr_stats) begin
            noise_drop_cnt <= '0;
            sat_cnt        <= '0;
        end else begin
            if (drop && (noise_drop_cnt != '1)) begin
                noise_drop_cnt <= noise_drop_cnt + CNT_ONE;
            end
            if (sat_event && (sat_cnt != '1)) begin
                sat_cnt <= sat_cnt + CNT_ONE;
            end
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_noise_injector.sv
// Directed-vector bench for noise_injector: per-cycle stimulus table with
// hand-computed expectations plus hand-written multi-cycle sequences.
module tb_noise_injector;

    logic              clk;
    logic              rstn;
    logic              en;
    logic              bypass;
    logic              clr_stats;
    logic signed [7:0] noise_in;
    logic              noise_valid;
    logic signed [7:0] sig_in;
    logic              sig_valid;
    logic              sig_ready;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        fifo_level;
    logic [15:0]       noise_drop_cnt;
    logic [15:0]       sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    noise_injector #(.SIG_W(8), .NOISE_W(8), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .bypass         (bypass),
        .clr_stats      (clr_stats),
        .noise_in       (noise_in),
        .noise_valid    (noise_valid),
        .sig_in         (sig_in),
        .sig_valid      (sig_valid),
        .sig_ready      (sig_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .noise_drop_cnt (noise_drop_cnt),
        .sat_cnt        (sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic en;
        logic byp;
        logic clr;
        logic nv;
        int   noise;
        logic sv;
        int   sig;
        logic ordy;
        logic e_rdy;
        logic e_ov;
        int   e_od;
        int   e_lvl;
        int   e_drop;
        int   e_sat;
    } vec_t;

    function automatic vec_t mk(logic e, logic b, logic c, logic nv, int nz, logic sv, int sg,
                                logic ordy, logic e_rdy, logic e_ov, int e_od, int e_lvl,
                                int e_drop, int e_sat);
        vec_t v;
        v.en = e; v.byp = b; v.clr = c; v.nv = nv; v.noise = nz; v.sv = sv; v.sig = sg;
        v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl;
        v.e_drop = e_drop; v.e_sat = e_sat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic b, input logic c, input logic nv,
                         input int nz, input logic sv, input int sg, input logic ordy);
        en = e; bypass = b; clr_stats = c; noise_valid = nv; noise_in = 8'(nz);
        sig_valid = sv; sig_in = 8'(sg); out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.en, v.byp, v.clr, v.nv, v.noise, v.sv, v.sig, v.ordy);
        #1;
        chk({tag, ".sig_ready"}, int'(sig_ready), int'(v.e_rdy));
        step();
        chk({tag, ".out_valid"}, int'(out_valid), int'(v.e_ov));
        if (v.e_ov) chk({tag, ".out_data"}, int'(out_data), v.e_od);
        chk({tag, ".fifo_level"}, int'(fifo_level), v.e_lvl);
        chk({tag, ".drop_cnt"}, int'(noise_drop_cnt), v.e_drop);
        chk({tag, ".sat_cnt"}, int'(sat_cnt), v.e_sat);
    endtask

    vec_t vt[20];

    initial begin
        //          en b  c  nv noise sv sig   ordy rdy ov od    lvl drop sat
        vt[0]  = mk(1, 0, 0, 1,  5,   0, 0,    1,   0,  0, 0,    1,  0,   0);
        vt[1]  = mk(1, 0, 0, 1, -3,   0, 0,    1,   1,  0, 0,    2,  0,   0);
        vt[2]  = mk(1, 0, 0, 1,  0,   1, 40,   1,   1,  1, 45,   2,  0,   0);
        vt[3]  = mk(1, 0, 0, 0,  0,   1, 40,   1,   1,  1, 37,   1,  0,   0);
        vt[4]  = mk(1, 0, 0, 0,  0,   1, -40,  1,   1,  1, -40,  0,  0,   0);
        vt[5]  = mk(1, 0, 0, 0,  0,   0, 0,    1,   0,  0, 0,    0,  0,   0);
        vt[6]  = mk(1, 0, 0, 1,  100, 0, 0,    1,   0,  0, 0,    1,  0,   0);
        vt[7]  = mk(1, 0, 0, 1, -100, 1, 100,  1,   1,  1, 127,  1,  0,   1);
        vt[8]  = mk(1, 0, 0, 0,  0,   1, -100, 1,   1,  1, -128, 0,  0,   2);
        vt[9]  = mk(1, 0, 0, 0,  0,   0, 0,    1,   0,  0, 0,    0,  0,   2);
        vt[10] = mk(1, 0, 0, 0,  0,   1, -7,   1,   0,  0, 0,    0,  0,   2);
        vt[11] = mk(1, 1, 0, 0,  0,   1, -7,   1,   1,  1, -7,   0,  0,   2);
        vt[12] = mk(1, 1, 0, 0,  0,   0, 0,    1,   1,  0, 0,    0,  0,   2);
        vt[13] = mk(0, 0, 0, 1,  9,   0, 0,    1,   0,  0, 0,    0,  0,   2);
        vt[14] = mk(1, 0, 0, 1,  27,  0, 0,    1,   0,  0, 0,    1,  0,   2);
        vt[15] = mk(1, 0, 0, 0,  0,   1, 100,  1,   1,  1, 127,  0,  0,   2);
        vt[16] = mk(1, 0, 0, 1, -28,  0, 0,    1,   0,  0, 0,    1,  0,   2);
        vt[17] = mk(1, 0, 0, 0,  0,   1, -100, 1,   1,  1, -128, 0,  0,   2);
        vt[18] = mk(1, 0, 0, 0,  0,   0, 0,    1,   0,  0, 0,    0,  0,   2);
        vt[19] = mk(1, 0, 1, 0,  0,   0, 0,    1,   0,  0, 0,    0,  0,   0);

        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #12;
        chk("rst.fifo_level", int'(fifo_level), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_data", int'(out_data), 0);
        chk("rst.drop_cnt", int'(noise_drop_cnt), 0);
        chk("rst.sat_cnt", int'(sat_cnt), 0);
        en = 1'b1;
        #1;
        chk("rst.sig_ready", int'(sig_ready), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) apply(vt[i], i);

        // Fill past capacity: values 0..15 stored, 16..19 dropped.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 1, i, 0, 0, 1);
            step();
        end
        chk("fill.fifo_level", int'(fifo_level), 16);
        chk("fill.drop_cnt", int'(noise_drop_cnt), 4);

        // Full FIFO with same-cycle push and pop: head (0) consumed, 50 accepted.
        drive(1, 0, 0, 1, 50, 1, 10, 1);
        #1;
        chk("fullpp.sig_ready", int'(sig_ready), 1);
        step();
        chk("fullpp.out_data", int'(out_data), 10);
        chk("fullpp.out_valid", int'(out_valid), 1);
        chk("fullpp.fifo_level", int'(fifo_level), 16);
        chk("fullpp.drop_cnt", int'(noise_drop_cnt), 4);

        // Downstream stall for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 1, 20, 0);
            #1;
            chk($sformatf("hold%0d.sig_ready", i), int'(sig_ready), 0);
            step();
            chk($sformatf("hold%0d.out_valid", i), int'(out_valid), 1);
            chk($sformatf("hold%0d.out_data", i), int'(out_data), 10);
            chk($sformatf("hold%0d.fifo_level", i), int'(fifo_level), 16);
        end
        drive(1, 0, 0, 0, 0, 1, 20, 1);
        #1;
        chk("release.sig_ready", int'(sig_ready), 1);
        step();
        chk("release.out_data", int'(out_data), 21);
        chk("release.out_valid", int'(out_valid), 1);
        chk("release.fifo_level", int'(fifo_level), 15);

        // Disabled stage: pending output drains, nothing accepted.
        drive(0, 0, 0, 1, 3, 1, 20, 1);
        #1;
        chk("dis.sig_ready", int'(sig_ready), 0);
        step();
        chk("dis.out_valid", int'(out_valid), 0);
        chk("dis.fifo_level", int'(fifo_level), 15);
        chk("dis.drop_cnt", int'(noise_drop_cnt), 4);

        // Six accepts bring level to 9 with a valid output pending.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 1);
            step();
        end
        chk("pre_rst.fifo_level", int'(fifo_level), 9);
        chk("pre_rst.out_valid", int'(out_valid), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        rstn = 1'b0;
        #1;
        chk("mrst.fifo_level", int'(fifo_level), 0);
        chk("mrst.out_valid", int'(out_valid), 0);
        chk("mrst.drop_cnt", int'(noise_drop_cnt), 0);
        chk("mrst.sat_cnt", int'(sat_cnt), 0);
        #1;
        rstn = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, i, 0, 0, 1);
            step();
        end
        chk("refill.fifo_level", int'(fifo_level), 16);
        drive(1, 0, 1, 1, 7, 0, 0, 1);
        step();
        chk("clrdrop.drop_cnt", int'(noise_drop_cnt), 0);
        chk("clrdrop.fifo_level", int'(fifo_level), 16);
        drive(1, 0, 0, 1, 7, 0, 0, 1);
        step();
        chk("drop_after_clr.drop_cnt", int'(noise_drop_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
